matrix_mult4x4: RTL and testbench
=================================

Name: matrix_mult4x4

Overview:
- Fixed-size 4x4 matrix multiplier; an execution engine drives it over 256-bit buses.
- Holds two operand matrices, A and B, loaded one at a time from a shared input bus.
- On command it computes C = A x B sequentially, one result element per cycle.
- It raises a flag when C is valid on the output bus.

Parameters:
- DW, 16: element width in bits; unsigned.
- N, 4: matrix dimension; the bus width is N*N*DW = 256.

Ports:
- clk  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- data_out  out  256  result matrix C, packed.
- flag  out  1  high when C is complete and valid.
- data_in  in  256  operand matrix, packed.
- rw  in  1  0 = load operand, 1 = start multiply.
- en  in  1  command qualifier; no action when 0.
- mat_decide  in  1  operand select for loads: 0 = A, 1 = B.

Behaviour:
- Packing: element [r][c] occupies bits [(r*4+c)*16 +: 16]; element [0][0] is in the LSBs. Applies to A, B and C.
- Reset (RESET=0, asynchronous):
  - A, B, C cleared to 0.
  - flag=0, busy=0, index=0.
  - data_out=0.
- Reset mid-computation aborts the computation with no partial result retained.
- States: IDLE, BUSY.
- IDLE, en=1, rw=0:
  - At the clock edge, data_in is written to A (mat_decide=0) or to B (mat_decide=1).
  - flag is cleared.
- IDLE, en=1, rw=1:
  - C is cleared, flag cleared, index set to 0.
  - Transition to BUSY.
- BUSY, each cycle:
  - C[index] <= sum over k=0..3 of A[r][k]*B[k][c], with r=index/4 and c=index%4.
  - Products are 32 bits; the sum is truncated to the low 16 bits (mod 2^16).
  - index increments.
- On the cycle that writes index 15:
  - Transition to IDLE; flag <= 1.
  - flag is therefore first seen high 16 rising edges after the start edge.
- In BUSY, all commands (loads and starts) are ignored; A and B stay stable.
- flag stays high until the next load or start, or until reset.
- A start issued while flag=1 recomputes from the current A and B.
- data_out is the C register at all times, including partial values during BUSY. Consumers sample it only while flag=1.
- en=0: state holds; nothing changes.
- An operand load takes effect at the clock edge of the command. The same register can be reloaded any number of times.

Decomposition:
- Shared package:
  - DW, N, BUS_W (256).
  - A packed element-slice helper function (row, col) -> bit offset.
  - State enum {IDLE, BUSY}.
- One sub-module, mat_dot4: combinational 4-term dot product of two 4-element 16-bit vectors, giving a 16-bit truncated result.
  - Instantiated once; the top selects row r of A and column c of B through muxes driven by index.

Test Plan:
- Reset: assert RESET=0 mid-simulation -> data_out=0 and flag=0 immediately, without waiting for a clock edge.
- Identity: load A=identity (mat_decide=0), load B with elements 1..16 row-major (mat_decide=1), start -> flag rises exactly 16 edges after the start edge; data_out equals B.
- Constant: A all 2, B all 3 -> every C element = 24 (0x0018); flag stays high until the next command.
- Overflow wrap:
  - A all 0xFFFF, B all 0xFFFF -> every element = 0x0004 (4 x 0xFFFE0001 mod 2^16).
  - A all 0x0100, B all 0x0100 -> every element = 0x0000.
- Non-commutative operand select:
  - A=[[1,2,0,0],[3,4,0,0],0,0], B=[[5,6,0,0],[7,8,0,0],0,0] -> C[0][0..1]=19,22 and C[1][0..1]=43,50.
  - Swap the mat_decide values used for the two loads -> C[0][0..1]=23,34 and C[1][0..1]=31,46.
- Busy protection and abort:
  - During BUSY, issue a load of all 0xFFFF into A -> the result is unchanged from the prior expectation.
  - Start again, then pull RESET low at cycle 8 -> flag=0 and data_out=0.
  - After reset, A=B=0, so a start yields all zeros with flag=1 after 16 edges.

Source files
------------

// File: rtl/matrix_mult4x4_pkg.sv
// Shared sizes, state encoding and packing helper
// for the 4x4 matrix multiplier.
package matrix_mult4x4_pkg;

    localparam int DW    = 16;
    localparam int N     = 4;
    localparam int BUS_W = N * N * DW;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N * N);
    localparam int OFF_W = $clog2(BUS_W);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    // Element [row][col] sits at ((row*N)+col)*DW; [0][0] in the LSBs.
    function automatic logic [OFF_W-1:0] elem_off(
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col
    );
        return OFF_W'((int'(row) * N + int'(col)) * DW);
    endfunction

endpackage

// File: rtl/matrix_mult4x4_if.sv
// Operand/result bus between the execution engine
// (master) and the matrix multiplier (slave).
interface matrix_mult4x4_if;
    import matrix_mult4x4_pkg::*;

    logic [BUS_W-1:0] data_in;
    logic [BUS_W-1:0] data_out;
    logic             flag;
    logic             rw;
    logic             en;
    logic             mat_decide;

    modport master (
        output data_in,
        output rw,
        output en,
        output mat_decide,
        input  data_out,
        input  flag
    );

    modport slave (
        input  data_in,
        input  rw,
        input  en,
        input  mat_decide,
        output data_out,
        output flag
    );

endinterface

// File: rtl/matrix_mult4x4_mat_dot4.sv
// Combinational 4-term dot product, result truncated
// to DW bits (mod 2^DW).
module mat_dot4
    import matrix_mult4x4_pkg::*;
(
    input  logic [N-1:0][DW-1:0] a_i,
    input  logic [N-1:0][DW-1:0] b_i,
    output logic [DW-1:0]        dot_o
);

    logic [2*DW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + ((2*DW)'(a_i[k]) * (2*DW)'(b_i[k]));
        end
        dot_o = acc[DW-1:0];
    end

endmodule

// File: rtl/matrix_mult4x4.sv
// 4x4 matrix multiplier: loads A/B from a shared bus and
// computes C = A x B one element per cycle.
module matrix_mult4x4
    import matrix_mult4x4_pkg::*;
(
    input logic             clk,
    input logic             RESET,
    matrix_mult4x4_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N * N - 1);

    state_e           state_q;
    logic [CNT_W-1:0] idx_q;
    logic [BUS_W-1:0] a_q;
    logic [BUS_W-1:0] b_q;
    logic [BUS_W-1:0] c_q;
    logic             flag_q;

    logic [IDX_W-1:0]     row;
    logic [IDX_W-1:0]     col;
    logic [N-1:0][DW-1:0] a_row;
    logic [N-1:0][DW-1:0] b_col;
    logic [DW-1:0]        elem_d;

    assign row = idx_q[CNT_W-1 -: IDX_W];
    assign col = idx_q[IDX_W-1:0];

    // Row r of A and column c of B feed the single dot-product unit.
    for (genvar k = 0; k < N; k++) begin : g_sel
        assign a_row[k] = a_q[elem_off(row, IDX_W'(k)) +: DW];
        assign b_col[k] = b_q[elem_off(IDX_W'(k), col) +: DW];
    end

    mat_dot4 u_dot (
        .a_i   (a_row),
        .b_i   (b_col),
        .dot_o (elem_d)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            flag_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        flag_q <= 1'b0;
                        if (bus.rw) begin
                            c_q     <= '0;
                            idx_q   <= '0;
                            state_q <= BUSY;
                        end else if (bus.mat_decide) begin
                            b_q <= bus.data_in;
                        end else begin
                            a_q <= bus.data_in;
                        end
                    end
                end
                BUSY: begin
                    c_q[elem_off(row, col) +: DW] <= elem_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_q <= IDLE;
                        flag_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out = c_q;
    assign bus.flag     = flag_q;

endmodule

// File: tb/tb_matrix_mult4x4.sv
// Self-checking bench for matrix_mult4x4 against a
// plain-arithmetic matrix product model.
module tb_matrix_mult4x4;
    import matrix_mult4x4_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    logic [BUS_W-1:0] mA;
    logic [BUS_W-1:0] mB;

    matrix_mult4x4_if mm_if ();

    matrix_mult4x4 dut (
        .clk   (clk),
        .RESET (rst_n),
        .bus   (mm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [BUS_W-1:0] got,
                       input logic [BUS_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int unsigned el(input logic [BUS_W-1:0] m,
                                       input int r, input int c);
        return int'((m >> ((r * 4 + c) * 16)) & 256'hFFFF);
    endfunction

    function automatic logic [BUS_W-1:0] put(input logic [BUS_W-1:0] m,
                                             input int r, input int c,
                                             input int unsigned v);
        logic [BUS_W-1:0] r_m;
        r_m = m;
        r_m[(r * 4 + c) * 16 +: 16] = v[15:0];
        return r_m;
    endfunction

    function automatic logic [BUS_W-1:0] ref_mul(input logic [BUS_W-1:0] a,
                                                 input logic [BUS_W-1:0] b);
        logic [BUS_W-1:0] res;
        longint unsigned  s;
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'(el(a, r, k)) * longint'(el(b, k, c));
                res = put(res, r, c, int'(s % 65536));
            end
        return res;
    endfunction

    function automatic logic [BUS_W-1:0] fill(input int unsigned v);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m = put(m, i / 4, i % 4, v);
        return m;
    endfunction

    task automatic load(input logic md, input logic [BUS_W-1:0] m);
        @(negedge clk);
        mm_if.en = 1'b1;
        mm_if.rw = 1'b0;
        mm_if.mat_decide = md;
        mm_if.data_in = m;
        @(negedge clk);
        mm_if.en = 1'b0;
        if (md) mB = m;
        else mA = m;
    endtask

    task automatic start();
        @(negedge clk);
        mm_if.en = 1'b1;
        mm_if.rw = 1'b1;
        @(negedge clk);
        mm_if.en = 1'b0;
        mm_if.rw = 1'b0;
    endtask

    task automatic wait_flag(output int cnt);
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (mm_if.flag) break;
        end
    endtask

    task automatic run(input string tag);
        int cnt;
        start();
        wait_flag(cnt);
        chk({tag, "_lat"}, BUS_W'(cnt), BUS_W'(16));
        chk({tag, "_flag"}, BUS_W'(mm_if.flag), BUS_W'(1));
        chk({tag, "_c"}, mm_if.data_out, ref_mul(mA, mB));
    endtask

    logic [BUS_W-1:0] ident, seq, p, q, rnd;
    int cnt;

    initial begin
        n_chk = 0;
        n_pass = 0;
        mA = '0;
        mB = '0;
        mm_if.en = 1'b0;
        mm_if.rw = 1'b0;
        mm_if.mat_decide = 1'b0;
        mm_if.data_in = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_dout", mm_if.data_out, '0);
        chk("rst_flag", BUS_W'(mm_if.flag), '0);
        @(negedge clk);
        rst_n = 1'b1;

        ident = '0;
        seq = '0;
        for (int i = 0; i < 4; i++) ident = put(ident, i, i, 1);
        for (int i = 0; i < 16; i++) seq = put(seq, i / 4, i % 4, i + 1);
        load(1'b0, ident);
        load(1'b1, seq);
        run("ident");
        chk("ident_eqB", mm_if.data_out, seq);

        load(1'b0, fill(2));
        chk("load_clr_flag", BUS_W'(mm_if.flag), '0);
        load(1'b1, fill(3));
        run("const");
        chk("const_24", mm_if.data_out, fill(24));
        repeat (5) @(negedge clk);
        chk("flag_hold", BUS_W'(mm_if.flag), BUS_W'(1));

        load(1'b0, fill(16'hFFFF));
        chk("flag_clr", BUS_W'(mm_if.flag), '0);
        load(1'b1, fill(16'hFFFF));
        run("ovf_ffff");
        chk("ovf_4", mm_if.data_out, fill(4));
        load(1'b0, fill(16'h0100));
        load(1'b1, fill(16'h0100));
        run("ovf_100");
        chk("ovf_0", mm_if.data_out, '0);

        p = put(put(put(put('0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4);
        q = put(put(put(put('0, 0, 0, 5), 0, 1, 6), 1, 0, 7), 1, 1, 8);
        load(1'b0, p);
        load(1'b1, q);
        run("pq");
        chk("pq_00", BUS_W'(el(mm_if.data_out, 0, 0)), BUS_W'(19));
        chk("pq_01", BUS_W'(el(mm_if.data_out, 0, 1)), BUS_W'(22));
        chk("pq_10", BUS_W'(el(mm_if.data_out, 1, 0)), BUS_W'(43));
        chk("pq_11", BUS_W'(el(mm_if.data_out, 1, 1)), BUS_W'(50));
        load(1'b1, p);
        load(1'b0, q);
        run("qp");
        chk("qp_00", BUS_W'(el(mm_if.data_out, 0, 0)), BUS_W'(23));
        chk("qp_01", BUS_W'(el(mm_if.data_out, 0, 1)), BUS_W'(34));
        chk("qp_10", BUS_W'(el(mm_if.data_out, 1, 0)), BUS_W'(31));
        chk("qp_11", BUS_W'(el(mm_if.data_out, 1, 1)), BUS_W'(46));

        // Load attempt mid-computation must be ignored.
        start();
        repeat (3) @(negedge clk);
        chk("busy_flag", BUS_W'(mm_if.flag), '0);
        mm_if.en = 1'b1;
        mm_if.rw = 1'b0;
        mm_if.mat_decide = 1'b0;
        mm_if.data_in = fill(16'hFFFF);
        @(negedge clk);
        mm_if.en = 1'b0;
        wait_flag(cnt);
        chk("busy_lat", BUS_W'(cnt + 4), BUS_W'(16));
        chk("busy_c", mm_if.data_out, ref_mul(mA, mB));
        run("recalc");

        for (int t = 0; t < 6; t++) begin
            rnd = '0;
            for (int i = 0; i < 16; i++)
                rnd = put(rnd, i / 4, i % 4, $urandom & 32'hFFFF);
            load(1'($urandom), rnd);
            run("rand");
        end

        start();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_flag", BUS_W'(mm_if.flag), '0);
        chk("abort_dout", mm_if.data_out, '0);
        mA = '0;
        mB = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst");
        chk("post_rst_0", mm_if.data_out, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
